// File: rtl/sram_bridge_pkg.sv
// Shared types and constants for the memory-bus to asynchronous SRAM bridge.
// The write-verify option is selected with SRAM_BRIDGE_WRVERIFY_EN.
package sram_bridge_pkg;

    localparam int BUS_AW  = 16;
    localparam int SRAM_AW = 18;
    localparam int DW      = 16;

    typedef enum logic [2:0] {
        st_idle     = 3'd0,
        st_read     = 3'd1,
        st_wr_setup = 3'd2,
        st_wr_pulse = 3'd3,
        st_wr_hold  = 3'd4,
        st_verify   = 3'd5
    } state_e;

    typedef struct packed {
        logic [BUS_AW-1:0] addr;
        logic [DW-1:0]     wdata;
        logic              is_wr;
    } bus_req_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bus_req_slot.sv
// One-entry holding register for a bus request that arrives while an access
// is in flight; a request arriving while the entry is full is dropped.
module bus_req_slot
    import sram_bridge_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  logic     take,
    input  bus_req_t req_in,
    output bus_req_t req_out,
    output logic     valid,
    output logic     overrun
);

    // slot occupancy, stored request and sticky drop flag
    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            req_out <= '0;
            overrun <= 1'b0;
        end else if (load && (take || !valid)) begin
            // a take in the same cycle frees the entry for the new request
            valid   <= 1'b1;
            req_out <= req_in;
        end else if (take) begin
            valid   <= 1'b0;
        end else if (load) begin
            overrun <= 1'b1;
        end else begin
            valid   <= valid;
        end
    end

endmodule

// File: rtl/mem_bus_sram_bridge.sv
// Runs single-cycle bus requests against an asynchronous 16-bit SRAM.
// Define SRAM_BRIDGE_WRVERIFY_EN to add a read-back check after every write.
module mem_bus_sram_bridge
    import sram_bridge_pkg::*;
#(
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BUS_AW-1:0]  bus_addr,
    input  logic [DW-1:0]      bus_wdata,
    input  logic               bus_is_wr,
    input  logic               bus_mem_en,
    output logic [DW-1:0]      bus_rdata,
    output logic               bus_rd_valid,
    output logic               bus_wr_done,
    output logic               bus_busy,
    output logic               bus_overrun,
    output logic               verify_err,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [DW-1:0]      sram_dq_o,
    input  logic [DW-1:0]      sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam int CW = $clog2(max_int(RD_WAIT, WR_WAIT)) + 1;
    localparam logic [CW-1:0] RD_LOAD  = CW'(RD_WAIT - 1);
    localparam logic [CW-1:0] WR_LOAD  = CW'(WR_WAIT - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e      state_r, state_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    bus_req_t    cur_r, cur_nxt_s;
    bus_req_t    bus_req_s, slot_req_s, launch_req_s;
    logic        slot_valid_s, slot_load_s, slot_take_s, slot_valid_nxt_s;
    logic        rd_capture_s, wr_finish_s;
    logic        ce_n_nxt_s, oe_n_nxt_s, we_n_nxt_s, dq_oe_nxt_s;
`ifdef SRAM_BRIDGE_WRVERIFY_EN
    logic        verify_chk_s;
`endif

    assign bus_req_s        = '{addr: bus_addr, wdata: bus_wdata, is_wr: bus_is_wr};
    assign slot_take_s      = (state_r == st_idle) && slot_valid_s;
    assign slot_load_s      = bus_mem_en && ((state_r != st_idle) || slot_valid_s);
    assign slot_valid_nxt_s = slot_load_s || (slot_valid_s && !slot_take_s);
    // a waiting request always has priority over the one on the bus
    assign launch_req_s     = slot_valid_s ? slot_req_s : bus_req_s;

    bus_req_slot u_slot (
        .clk     (clk),
        .rst     (rst),
        .load    (slot_load_s),
        .take    (slot_take_s),
        .req_in  (bus_req_s),
        .req_out (slot_req_s),
        .valid   (slot_valid_s),
        .overrun (bus_overrun)
    );

    // access sequencing: next state, wait counter and completion events
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        cur_nxt_s    = cur_r;
        rd_capture_s = 1'b0;
        wr_finish_s  = 1'b0;
`ifdef SRAM_BRIDGE_WRVERIFY_EN
        verify_chk_s = 1'b0;
`endif
        case (state_r)
            st_idle: begin
                if (slot_valid_s || bus_mem_en) begin
                    cur_nxt_s = launch_req_s;
                    if (launch_req_s.is_wr) begin
                        state_nxt_s = st_wr_setup;
                        cnt_nxt_s   = WR_LOAD;
                    end else begin
                        state_nxt_s = st_read;
                        cnt_nxt_s   = RD_LOAD;
                    end
                end else begin
                    state_nxt_s = st_idle;
                end
            end
            st_read: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s  = st_idle;
                    rd_capture_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            st_wr_setup: begin
                state_nxt_s = st_wr_pulse;
            end
            st_wr_pulse: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = st_wr_hold;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            st_wr_hold: begin
`ifdef SRAM_BRIDGE_WRVERIFY_EN
                state_nxt_s = st_verify;
                cnt_nxt_s   = RD_LOAD;
`else
                state_nxt_s = st_idle;
                wr_finish_s = 1'b1;
`endif
            end
`ifdef SRAM_BRIDGE_WRVERIFY_EN
            st_verify: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s  = st_idle;
                    wr_finish_s  = 1'b1;
                    verify_chk_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
`endif
            default: begin
                state_nxt_s = st_idle;
            end
        endcase
    end

    // strobe levels for the state being entered, so the pins are registered
    always_comb begin
        ce_n_nxt_s  = 1'b1;
        oe_n_nxt_s  = 1'b1;
        we_n_nxt_s  = 1'b1;
        dq_oe_nxt_s = 1'b0;
        case (state_nxt_s)
            st_read, st_verify: begin
                ce_n_nxt_s = 1'b0;
                oe_n_nxt_s = 1'b0;
            end
            st_wr_setup, st_wr_hold: begin
                ce_n_nxt_s  = 1'b0;
                dq_oe_nxt_s = 1'b1;
            end
            st_wr_pulse: begin
                ce_n_nxt_s  = 1'b0;
                we_n_nxt_s  = 1'b0;
                dq_oe_nxt_s = 1'b1;
            end
            default: begin
                ce_n_nxt_s = 1'b1;
            end
        endcase
    end

    // state, SRAM pins and bus-side handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= st_idle;
            cnt_r        <= CNT_ZERO;
            cur_r        <= '0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_ub_n    <= 1'b1;
            sram_lb_n    <= 1'b1;
            sram_dq_oe   <= 1'b0;
            sram_addr    <= '0;
            sram_dq_o    <= '0;
            bus_rdata    <= '0;
            bus_rd_valid <= 1'b0;
            bus_wr_done  <= 1'b0;
            bus_busy     <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            cur_r        <= cur_nxt_s;
            sram_ce_n    <= ce_n_nxt_s;
            sram_oe_n    <= oe_n_nxt_s;
            sram_we_n    <= we_n_nxt_s;
            sram_ub_n    <= ce_n_nxt_s;
            sram_lb_n    <= ce_n_nxt_s;
            sram_dq_oe   <= dq_oe_nxt_s;
            sram_addr    <= {{(SRAM_AW-BUS_AW){1'b0}}, cur_nxt_s.addr};
            sram_dq_o    <= cur_nxt_s.wdata;
            bus_rd_valid <= rd_capture_s;
            bus_wr_done  <= wr_finish_s;
            bus_busy     <= (state_nxt_s != st_idle) || slot_valid_nxt_s;
            if (rd_capture_s) begin
                bus_rdata <= sram_dq_i;
            end else begin
                bus_rdata <= bus_rdata;
            end
        end
    end

`ifdef SRAM_BRIDGE_WRVERIFY_EN
    // sticky flag for a read-back that differs from the data just written
    always_ff @(posedge clk) begin
        if (rst) begin
            verify_err <= 1'b0;
        end else if (verify_chk_s && (sram_dq_i != cur_r.wdata)) begin
            verify_err <= 1'b1;
        end else begin
            verify_err <= verify_err;
        end
    end
`else
    assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_sram_bridge.sv
// Directed bench for mem_bus_sram_bridge with a behavioural async SRAM model.
// Expectations follow SRAM_BRIDGE_WRVERIFY_EN when the bench is built with it.
module tb_mem_bus_sram_bridge;

    localparam int RD_WAIT = 2;
    localparam int WR_WAIT = 2;
`ifdef SRAM_BRIDGE_WRVERIFY_EN
    localparam int   VFY       = RD_WAIT;
    localparam logic EXP_VERR  = 1'b1;
`else
    localparam int   VFY       = 0;
    localparam logic EXP_VERR  = 1'b0;
`endif
    localparam int RD_LAT = RD_WAIT + 1;
    localparam int WR_LAT = WR_WAIT + 3 + VFY;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_is_wr, bus_mem_en, bus_rd_valid, bus_wr_done, bus_busy, bus_overrun;
    logic        verify_err;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o, sram_dq_i;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_bus_sram_bridge #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
        .clk(clk), .rst(rst),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_is_wr(bus_is_wr),
        .bus_mem_en(bus_mem_en), .bus_rdata(bus_rdata), .bus_rd_valid(bus_rd_valid),
        .bus_wr_done(bus_wr_done), .bus_busy(bus_busy), .bus_overrun(bus_overrun),
        .verify_err(verify_err), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
        .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n),
        .sram_lb_n(sram_lb_n)
    );

    // SRAM model: combinational read, write while we_n is low, optional bit-0 corruption
    logic [15:0] mem [0:1023];
    logic        pl_en, corrupt;
    logic [9:0]  pl_addr;
    logic [15:0] pl_data;

    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 16'h0000;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (!sram_ce_n && !sram_we_n && sram_dq_oe)
            mem[sram_addr[9:0]] <= sram_dq_o ^ {15'd0, corrupt};
    end

    typedef struct {
        logic        is_wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;
    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [15:0] a, input logic [15:0] d);
        bus_is_wr  = wr;
        bus_addr   = a;
        bus_wdata  = d;
        bus_mem_en = 1'b1;
        tick();
        bus_mem_en = 1'b0;
    endtask

    // waits for the completion pulse of the access issued at cycle 0
    task automatic wait_done(input logic wr, output int lat, output logic [15:0] rd,
                             output logic [17:0] addr1);
        lat   = -1;
        rd    = 16'h0000;
        addr1 = 18'h0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) addr1 = sram_addr;
            if ((wr ? bus_wr_done : bus_rd_valid) && lat < 0) begin
                lat = c;
                rd  = bus_rdata;
            end
            tick();
            if (lat >= 0) break;
        end
    endtask

    initial begin
        int          lat, wc, rc, npulse;
        logic [15:0] rd;
        logic [17:0] a1;

        vecs[0] = '{1'b1, 16'h0100, 16'hAAAA, 16'h0000};
        vecs[1] = '{1'b1, 16'h0101, 16'h5555, 16'h0000};
        vecs[2] = '{1'b0, 16'h0100, 16'h0000, 16'hAAAA};
        vecs[3] = '{1'b0, 16'h0101, 16'h0000, 16'h5555};
        vecs[4] = '{1'b0, 16'h0040, 16'h0000, 16'h5A5A};
        vecs[5] = '{1'b1, 16'h03FF, 16'hFFFF, 16'h0000};
        vecs[6] = '{1'b0, 16'h03FF, 16'h0000, 16'hFFFF};
        vecs[7] = '{1'b1, 16'h0000, 16'h0000, 16'h0000};
        vecs[8] = '{1'b0, 16'h0000, 16'h0000, 16'h0000};

        rst = 1'b1; bus_addr = 16'h0; bus_wdata = 16'h0; bus_is_wr = 1'b0; bus_mem_en = 1'b0;
        corrupt = 1'b0; pl_en = 1'b1; pl_addr = 10'h123; pl_data = 16'hBEEF;
        tick();
        pl_en = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
        chk("rst_dq_oe", sram_dq_oe, 32'h0);
        chk("rst_flags", {bus_rd_valid, bus_wr_done, bus_busy, bus_overrun, verify_err}, 32'h0);
        chk("rst_rdata", bus_rdata, 32'h0);
        chk("rst_addr_dq", {sram_addr[15:0], sram_dq_o}, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // single read: oe_n low cycles 1-2, rd_valid at cycle 3
        issue(1'b0, 16'h0123, 16'h0000);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("rd_oe_n_c%0d", c), sram_oe_n, (c <= 2) ? 32'h0 : 32'h1);
            chk($sformatf("rd_valid_c%0d", c), bus_rd_valid, (c == 3) ? 32'h1 : 32'h0);
            if (c == 1) chk("rd_busy_c1", bus_busy, 32'h1);
            if (c == 3) chk("rd_rdata", bus_rdata, 32'hBEEF);
            tick();
        end

        // single write: we_n low cycles 2-3, dq_oe cycles 1-4, wr_done at WR_LAT
        issue(1'b1, 16'h0040, 16'h5A5A);
        for (int c = 1; c <= WR_LAT + 1; c++) begin
            @(negedge clk);
            chk($sformatf("wr_we_n_c%0d", c), sram_we_n, (c == 2 || c == 3) ? 32'h0 : 32'h1);
            chk($sformatf("wr_dq_oe_c%0d", c), sram_dq_oe, (c >= 1 && c <= 4) ? 32'h1 : 32'h0);
            chk($sformatf("wr_done_c%0d", c), bus_wr_done, (c == WR_LAT) ? 32'h1 : 32'h0);
            tick();
        end
        chk("wr_mem_0040", mem[10'h040], 32'h5A5A);

        // table of isolated transactions
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].is_wr, vecs[i].addr, vecs[i].wdata);
            wait_done(vecs[i].is_wr, lat, rd, a1);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].is_wr ? WR_LAT : RD_LAT);
            chk($sformatf("vec%0d_addr", i), {14'd0, a1}, {16'd0, vecs[i].addr});
            if (!vecs[i].is_wr) chk($sformatf("vec%0d_rdata", i), rd, {16'd0, vecs[i].exp_rdata});
            tick();
        end

        // write then read at cycle 2: the read waits in the slot
        issue(1'b1, 16'h0050, 16'h1234);
        tick();
        issue(1'b0, 16'h0050, 16'h0000);
        wc = -1; rc = -1; rd = 16'h0;
        for (int c = 3; c <= 30; c++) begin
            @(negedge clk);
            if (bus_wr_done && wc < 0) begin
                wc = c;
                chk("pend_busy_at_wr_done", bus_busy, 32'h1);
            end
            if (bus_rd_valid && rc < 0) begin
                rc = c;
                rd = bus_rdata;
                chk("pend_busy_at_rd_valid", bus_busy, 32'h0);
            end
            tick();
            if (rc >= 0) break;
        end
        chk("pend_wr_done_cycle", wc, WR_LAT);
        chk("pend_rd_valid_cycle", rc, WR_LAT + RD_LAT);
        chk("pend_rdata", rd, 32'h1234);
        chk("pend_overrun", bus_overrun, 32'h0);

        // three requests back to back: third is dropped
        issue(1'b0, 16'h0123, 16'h0000);
        issue(1'b0, 16'h0040, 16'h0000);
        issue(1'b0, 16'h0100, 16'h0000);
        npulse = 0;
        for (int c = 3; c <= 20; c++) begin
            @(negedge clk);
            if (bus_rd_valid) npulse++;
            tick();
        end
        chk("ovr_rd_pulses", npulse, 32'd2);
        chk("ovr_last_rdata", bus_rdata, 32'h5A5A);
        chk("ovr_flag", bus_overrun, 32'h1);
        tick(); tick();
        chk("ovr_sticky", bus_overrun, 32'h1);

        // reset during WR_PULSE with a read waiting in the slot
        issue(1'b1, 16'h0070, 16'h7777);
        issue(1'b0, 16'h0070, 16'h0000);
        @(negedge clk);
        chk("abort_in_pulse", sram_we_n, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
        chk("abort_dq_oe", sram_dq_oe, 32'h0);
        chk("abort_busy", bus_busy, 32'h0);
        chk("abort_overrun", bus_overrun, 32'h0);
        npulse = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus_wr_done || bus_rd_valid || bus_busy) npulse++;
            tick();
        end
        chk("abort_quiet", npulse, 32'd0);

        // write with a corrupting SRAM
        corrupt = 1'b1;
        issue(1'b1, 16'h0060, 16'h00FF);
        wait_done(1'b1, lat, rd, a1);
        corrupt = 1'b0;
        chk("vfy_lat", lat, WR_LAT);
        chk("vfy_err", verify_err, {31'd0, EXP_VERR});
        chk("vfy_mem", mem[10'h060], 32'h00FE);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
